// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite slave exposing four 32-bit read/write registers with byte strobes.
// Independent one-entry AW and W buffers; a write commits once both are full and no B is pending.

module axi_lite_reg_slave #(
   parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
   parameter int unsigned C_S_AXI_ADDR_WIDTH = 4
) (
   input  logic                              S_AXI_ACLK,
   input  logic                              S_AXI_ARESET,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
   input  logic [2:0]                        S_AXI_AWPROT,
   input  logic                              S_AXI_AWVALID,
   output logic                              S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
   input  logic                              S_AXI_WVALID,
   output logic                              S_AXI_WREADY,
   output logic [1:0]                        S_AXI_BRESP,
   output logic                              S_AXI_BVALID,
   input  logic                              S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
   input  logic [2:0]                        S_AXI_ARPROT,
   input  logic                              S_AXI_ARVALID,
   output logic                              S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
   output logic [1:0]                        S_AXI_RRESP,
   output logic                              S_AXI_RVALID,
   input  logic                              S_AXI_RREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     slv_reg0,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     slv_reg1,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     slv_reg2,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     slv_reg3,
   output logic [3:0]                        reg_wr_pulse
);

   localparam int unsigned DW       = C_S_AXI_DATA_WIDTH;
   localparam int unsigned STRB_W   = C_S_AXI_DATA_WIDTH / 8;
   localparam int unsigned NUM_REGS = 4;
   localparam int unsigned IDX_W    = 2;

   logic [NUM_REGS-1:0][DW-1:0] regs_q, regs_d;
   logic                        aw_full_q, aw_full_d;
   logic [IDX_W-1:0]            aw_idx_q, aw_idx_d;
   logic                        w_full_q, w_full_d;
   logic [DW-1:0]               w_data_q, w_data_d;
   logic [STRB_W-1:0]           w_strb_q, w_strb_d;
   logic                        bvalid_q, bvalid_d;
   logic                        rvalid_q, rvalid_d;
   logic [DW-1:0]               rdata_q, rdata_d;
   logic [NUM_REGS-1:0]         pulse_q, pulse_d;

   logic aw_hs_c, w_hs_c, ar_hs_c, commit_c;
   logic unused_sigs;

   // Address offset bits, PROT and any address bits above the register index carry no meaning here.
   assign unused_sigs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

   // Ready is forced low during reset so no handshake can complete while state is being cleared.
   assign S_AXI_AWREADY = ~aw_full_q & ~S_AXI_ARESET;
   assign S_AXI_WREADY  = ~w_full_q  & ~S_AXI_ARESET;
   assign S_AXI_ARREADY = ~rvalid_q  & ~S_AXI_ARESET;

   assign aw_hs_c  = S_AXI_AWVALID & S_AXI_AWREADY;
   assign w_hs_c   = S_AXI_WVALID  & S_AXI_WREADY;
   assign ar_hs_c  = S_AXI_ARVALID & S_AXI_ARREADY;
   assign commit_c = aw_full_q & w_full_q & ~bvalid_q;

   always_comb begin
      regs_d    = regs_q;
      aw_full_d = aw_full_q;
      aw_idx_d  = aw_idx_q;
      w_full_d  = w_full_q;
      w_data_d  = w_data_q;
      w_strb_d  = w_strb_q;
      bvalid_d  = bvalid_q;
      rvalid_d  = rvalid_q;
      rdata_d   = rdata_q;
      pulse_d   = '0;

      // A commit needs both buffers full, so it can never coincide with a capture into either.
      if (commit_c) begin
         for (int unsigned k = 0; k < STRB_W; k++) begin
            if (w_strb_q[k]) begin
               regs_d[aw_idx_q][8*k +: 8] = w_data_q[8*k +: 8];
            end
         end
         aw_full_d         = 1'b0;
         w_full_d          = 1'b0;
         bvalid_d          = 1'b1;
         pulse_d[aw_idx_q] = 1'b1;
      end else if (bvalid_q && S_AXI_BREADY) begin
         bvalid_d = 1'b0;
      end

      if (aw_hs_c) begin
         aw_full_d = 1'b1;
         aw_idx_d  = S_AXI_AWADDR[3:2];
      end

      if (w_hs_c) begin
         w_full_d = 1'b1;
         w_data_d = S_AXI_WDATA;
         w_strb_d = S_AXI_WSTRB;
      end

      // Reads sample regs_q, so a same-edge commit is not visible to this read.
      if (ar_hs_c) begin
         rvalid_d = 1'b1;
         rdata_d  = regs_q[S_AXI_ARADDR[3:2]];
      end else if (rvalid_q && S_AXI_RREADY) begin
         rvalid_d = 1'b0;
      end
   end

   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET) begin
         regs_q    <= '0;
         aw_full_q <= 1'b0;
         aw_idx_q  <= '0;
         w_full_q  <= 1'b0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
         bvalid_q  <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         pulse_q   <= '0;
      end else begin
         regs_q    <= regs_d;
         aw_full_q <= aw_full_d;
         aw_idx_q  <= aw_idx_d;
         w_full_q  <= w_full_d;
         w_data_q  <= w_data_d;
         w_strb_q  <= w_strb_d;
         bvalid_q  <= bvalid_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
         pulse_q   <= pulse_d;
      end
   end

   assign S_AXI_BVALID = bvalid_q;
   assign S_AXI_BRESP  = 2'b00;
   assign S_AXI_RVALID = rvalid_q;
   assign S_AXI_RDATA  = rdata_q;
   assign S_AXI_RRESP  = 2'b00;
   assign slv_reg0     = regs_q[0];
   assign slv_reg1     = regs_q[1];
   assign slv_reg2     = regs_q[2];
   assign slv_reg3     = regs_q[3];
   assign reg_wr_pulse = pulse_q;

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Directed self-checking bench for axi_lite_reg_slave.
// Inputs change and outputs are sampled 1 ns after each rising edge.

module tb_axi_lite_reg_slave;

   logic        clk;
   logic        rst;
   logic [3:0]  awaddr;
   logic [2:0]  awprot;
   logic        awvalid, awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid, wready;
   logic [1:0]  bresp;
   logic        bvalid, bready;
   logic [3:0]  araddr;
   logic [2:0]  arprot;
   logic        arvalid, arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid, rready;
   logic [31:0] r0, r1, r2, r3;
   logic [3:0]  pulse;

   int n_vec;
   int n_err;

   axi_lite_reg_slave #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) dut (
      .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
      .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
      .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
      .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
      .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
      .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
      .slv_reg0(r0), .slv_reg1(r1), .slv_reg2(r2), .slv_reg3(r3), .reg_wr_pulse(pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Drives one write with AW and W presented together; returns BRESP and the pulse seen with BVALID.
   task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] br, output logic [3:0] pl, output bit to);
      bit aw_done, w_done, hs_aw, hs_w;
      int cnt;
      to = 1'b0; aw_done = 1'b0; w_done = 1'b0; cnt = 0;
      awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
      while (!(aw_done && w_done) && cnt < 20) begin
         hs_aw = awvalid && awready;
         hs_w  = wvalid && wready;
         tick();
         if (hs_aw) begin awvalid = 1'b0; aw_done = 1'b1; end
         if (hs_w)  begin wvalid = 1'b0;  w_done = 1'b1;  end
         cnt++;
      end
      if (!(aw_done && w_done)) to = 1'b1;
      awvalid = 1'b0; wvalid = 1'b0;
      cnt = 0;
      while (!bvalid && cnt < 20) begin tick(); cnt++; end
      if (!bvalid) to = 1'b1;
      br = bresp; pl = pulse;
      tick();
      bready = 1'b0;
   endtask

   task automatic do_read(input logic [3:0] a, output logic [31:0] d, output logic [1:0] rr, output bit to);
      int cnt;
      to = 1'b0; cnt = 0;
      araddr = a; arvalid = 1'b1;
      while (!arready && cnt < 20) begin tick(); cnt++; end
      if (!arready) to = 1'b1;
      tick();
      arvalid = 1'b0;
      cnt = 0;
      while (!rvalid && cnt < 20) begin tick(); cnt++; end
      if (!rvalid) to = 1'b1;
      d = rdata; rr = rresp;
      rready = 1'b1;
      tick();
      rready = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      tick(); tick();
      n_vec++; if ({awready, wready, arready} !== 3'b000) begin n_err++; $display("FAIL rst_readys got=%b exp=000", {awready, wready, arready}); end
      n_vec++; if ({bvalid, rvalid} !== 2'b00) begin n_err++; $display("FAIL rst_valids got=%b exp=00", {bvalid, rvalid}); end
      n_vec++; if (rdata !== 32'h0) begin n_err++; $display("FAIL rst_rdata got=%h exp=0", rdata); end
      n_vec++; if (pulse !== 4'h0) begin n_err++; $display("FAIL rst_pulse got=%b exp=0000", pulse); end
      n_vec++; if ({r3, r2, r1, r0} !== 128'h0) begin n_err++; $display("FAIL rst_regs got=%h exp=0", {r3, r2, r1, r0}); end
      rst = 1'b0;
      #1;
      n_vec++; if ({awready, wready, arready} !== 3'b111) begin n_err++; $display("FAIL rst_release_readys got=%b exp=111", {awready, wready, arready}); end
      tick();
   endtask

   task automatic test_basic;
      logic [1:0] br, rr; logic [3:0] pl; logic [31:0] d; bit to;
      for (int i = 0; i < 4; i++) begin
         do_write(4'(4 * i), 32'(i + 1), 4'hF, br, pl, to);
         n_vec++; if ({to, br} !== 3'b000) begin n_err++; $display("FAIL basic_wr%0d to/bresp got=%b exp=000", i, {to, br}); end
      end
      n_vec++; if ({r3, r2, r1, r0} !== {32'h4, 32'h3, 32'h2, 32'h1}) begin n_err++; $display("FAIL basic_regs got=%h exp=4/3/2/1", {r3, r2, r1, r0}); end
      for (int i = 0; i < 4; i++) begin
         do_read(4'(4 * i), d, rr, to);
         n_vec++; if ({to, rr, d} !== {1'b0, 2'b00, 32'(i + 1)}) begin n_err++; $display("FAIL basic_rd%0d to=%b rresp=%b data got=%h exp=%h", i, to, rr, d, 32'(i + 1)); end
      end
   endtask

   task automatic test_r_backpressure;
      araddr = 4'h8; arvalid = 1'b1;
      tick();
      arvalid = 1'b0;
      n_vec++; if ({rvalid, arready, rresp, rdata} !== {1'b1, 1'b0, 2'b00, 32'h3}) begin n_err++; $display("FAIL rbp_first rvalid=%b arready=%b rresp=%b rdata got=%h exp=3", rvalid, arready, rresp, rdata); end
      for (int k = 0; k < 3; k++) begin
         tick();
         n_vec++; if ({rvalid, arready, rdata} !== {1'b1, 1'b0, 32'h3}) begin n_err++; $display("FAIL rbp_hold%0d rvalid=%b arready=%b rdata got=%h exp=3", k, rvalid, arready, rdata); end
      end
      rready = 1'b1;
      tick();
      rready = 1'b0;
      n_vec++; if ({rvalid, arready} !== 2'b01) begin n_err++; $display("FAIL rbp_done rvalid/arready got=%b exp=01", {rvalid, arready}); end
   endtask

   task automatic test_strobe;
      logic [1:0] br; logic [3:0] pl; bit to;
      do_write(4'h4, 32'h11223344, 4'hF, br, pl, to);
      do_write(4'h4, 32'hAABBCCDD, 4'b0101, br, pl, to);
      n_vec++; if (r1 !== 32'h11BB33DD) begin n_err++; $display("FAIL strobe_0101 got=%h exp=11bb33dd", r1); end
      n_vec++; if ({to, pl} !== 5'b00010) begin n_err++; $display("FAIL strobe_pulse got=%b exp=00010", {to, pl}); end
      do_write(4'hE, 32'hFFFFFFFF, 4'h0, br, pl, to);
      n_vec++; if (r3 !== 32'h4) begin n_err++; $display("FAIL strobe_zero_data got=%h exp=4", r3); end
      n_vec++; if ({to, pl} !== 5'b01000) begin n_err++; $display("FAIL strobe_zero_pulse got=%b exp=01000", {to, pl}); end
      n_vec++; if (pulse !== 4'h0) begin n_err++; $display("FAIL strobe_pulse_width got=%b exp=0000", pulse); end
   endtask

   task automatic test_w_before_aw;
      bready = 1'b0;
      wdata = 32'hCAFE0003; wstrb = 4'hF; wvalid = 1'b1;
      tick();
      wvalid = 1'b0;
      n_vec++; if ({wready, awready, bvalid} !== 3'b010) begin n_err++; $display("FAIL wfirst_capture wready/awready/bvalid got=%b exp=010", {wready, awready, bvalid}); end
      tick();
      n_vec++; if ({wready, bvalid} !== 2'b00) begin n_err++; $display("FAIL wfirst_wait wready/bvalid got=%b exp=00", {wready, bvalid}); end
      tick();
      awaddr = 4'hC; awvalid = 1'b1;
      tick();
      awvalid = 1'b0;
      n_vec++; if ({wready, awready, bvalid, pulse} !== 7'b0000000) begin n_err++; $display("FAIL wfirst_aw wready/awready/bvalid/pulse got=%b exp=0000000", {wready, awready, bvalid, pulse}); end
      tick();
      n_vec++; if ({bvalid, pulse} !== 5'b11000) begin n_err++; $display("FAIL wfirst_commit bvalid/pulse got=%b exp=11000", {bvalid, pulse}); end
      n_vec++; if (r3 !== 32'hCAFE0003) begin n_err++; $display("FAIL wfirst_reg3 got=%h exp=cafe0003", r3); end
      bready = 1'b1;
      tick();
      bready = 1'b0;
      n_vec++; if ({bvalid, pulse, awready, wready} !== 7'b0000011) begin n_err++; $display("FAIL wfirst_bdone bvalid/pulse/awready/wready got=%b exp=0000011", {bvalid, pulse, awready, wready}); end
   endtask

   task automatic test_b_backpressure;
      bready = 1'b0;
      awaddr = 4'h0; wdata = 32'hA; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
      n_vec++; if (bvalid !== 1'b0) begin n_err++; $display("FAIL bbp_e0 bvalid got=%b exp=0", bvalid); end
      tick();
      n_vec++; if ({bvalid, pulse, r0} !== {1'b1, 4'b0001, 32'hA}) begin n_err++; $display("FAIL bbp_commit1 bvalid=%b pulse=%b r0 got=%h exp=a", bvalid, pulse, r0); end
      awaddr = 4'h8; wdata = 32'hB; awvalid = 1'b1; wvalid = 1'b1;
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
      n_vec++; if ({bvalid, awready, wready} !== 3'b100) begin n_err++; $display("FAIL bbp_cap2 bvalid/awready/wready got=%b exp=100", {bvalid, awready, wready}); end
      for (int k = 0; k < 3; k++) begin
         tick();
         n_vec++; if ({bvalid, awready, wready, pulse, r2} !== {3'b100, 4'b0000, 32'h3}) begin n_err++; $display("FAIL bbp_hold%0d bvalid/awready/wready=%b pulse=%b r2 got=%h exp=3", k, {bvalid, awready, wready}, pulse, r2); end
      end
      bready = 1'b1;
      tick();
      n_vec++; if ({bvalid, pulse, r2} !== {1'b0, 4'b0000, 32'h3}) begin n_err++; $display("FAIL bbp_bhs bvalid=%b pulse=%b r2 got=%h exp=3", bvalid, pulse, r2); end
      tick();
      n_vec++; if ({bvalid, pulse, r2} !== {1'b1, 4'b0100, 32'hB}) begin n_err++; $display("FAIL bbp_commit2 bvalid=%b pulse=%b r2 got=%h exp=b", bvalid, pulse, r2); end
      tick();
      bready = 1'b0;
      n_vec++; if ({bvalid, pulse} !== 5'b00000) begin n_err++; $display("FAIL bbp_done bvalid/pulse got=%b exp=00000", {bvalid, pulse}); end
   endtask

   task automatic test_collision;
      bready = 1'b0;
      awaddr = 4'h0; wdata = 32'h5A5A0000; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
      araddr = 4'h1; arvalid = 1'b1;
      tick();
      arvalid = 1'b0;
      n_vec++; if ({rvalid, rdata} !== {1'b1, 32'hA}) begin n_err++; $display("FAIL coll_rdata rvalid=%b rdata got=%h exp=a", rvalid, rdata); end
      n_vec++; if ({bvalid, r0} !== {1'b1, 32'h5A5A0000}) begin n_err++; $display("FAIL coll_commit bvalid=%b r0 got=%h exp=5a5a0000", bvalid, r0); end
      rready = 1'b1; bready = 1'b1;
      tick();
      rready = 1'b0; bready = 1'b0;
      n_vec++; if ({rvalid, bvalid} !== 2'b00) begin n_err++; $display("FAIL coll_done rvalid/bvalid got=%b exp=00", {rvalid, bvalid}); end
   endtask

   task automatic test_reset_mid;
      bready = 1'b0;
      awaddr = 4'h8; awvalid = 1'b1;
      tick();
      awvalid = 1'b0;
      n_vec++; if (awready !== 1'b0) begin n_err++; $display("FAIL rmid_aw_captured awready got=%b exp=0", awready); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      n_vec++; if ({bvalid, awready, wready, r2} !== {3'b011, 32'h0}) begin n_err++; $display("FAIL rmid_after bvalid/awready/wready=%b r2 got=%h exp=0", {bvalid, awready, wready}, r2); end
      tick();
      wdata = 32'h77; wstrb = 4'hF; wvalid = 1'b1;
      tick();
      wvalid = 1'b0;
      tick(); tick();
      n_vec++; if ({bvalid, pulse, r2} !== {1'b0, 4'b0000, 32'h0}) begin n_err++; $display("FAIL rmid_stale_aw bvalid=%b pulse=%b r2 got=%h exp=0", bvalid, pulse, r2); end
      awaddr = 4'h4; awvalid = 1'b1;
      tick();
      awvalid = 1'b0;
      tick();
      n_vec++; if ({bvalid, pulse, r1, r2} !== {1'b1, 4'b0010, 32'h77, 32'h0}) begin n_err++; $display("FAIL rmid_fresh bvalid=%b pulse=%b r1 got=%h exp=77 r2 got=%h exp=0", bvalid, pulse, r1, r2); end
      bready = 1'b1;
      tick();
      bready = 1'b0;
      n_vec++; if (bvalid !== 1'b0) begin n_err++; $display("FAIL rmid_bdone bvalid got=%b exp=0", bvalid); end
   endtask

   initial begin
      n_vec = 0; n_err = 0;
      rst = 1'b1;
      awaddr = '0; awprot = '0; awvalid = 1'b0;
      wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
      araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
      test_reset();
      test_basic();
      test_r_backpressure();
      test_strobe();
      test_w_before_aw();
      test_b_backpressure();
      test_collision();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

endmodule
